// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types, defaults and a helper for the SPI slave.
//                It defines the FSM state enum, the latched bus-mode struct
//                and the mapping from SCLK edges to sample and shift events.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_DATA_W      = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } spi_slv_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Translates raw SCLK rise/fall strobes into {sample, shift} strobes.
    // Leading edge = SCLK leaving its idle level, trailing = returning to it.
    function automatic logic [1:0] edge_sel(input spi_mode_t mode,
                                            input logic      rise,
                                            input logic      fall);
        logic lead;
        logic trail;
        lead  = mode.cpol ? fall : rise;
        trail = mode.cpol ? rise : fall;
        return mode.cpha ? {trail, lead} : {lead, trail};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : Multi-flop synchronizer for one asynchronous pin, followed
//                by a history flop for edge detection.
//  Ports       : clk_i   - system clock
//                rst_i   - synchronous active-high reset
//                async_i - asynchronous pin
//                level_o - synchronized level (last sync stage)
//                rise_o  - one-cycle strobe, synchronized 0->1
//                fall_o  - one-cycle strobe, synchronized 1->0
//  Revision    : 1.0  initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  =  sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] &  hist_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave
//  Description : Oversampled SPI slave, all four CPOL/CPHA modes, MSB first,
//                multi-byte frames while SS_n stays low. Received bytes are
//                delivered with a one-cycle rx_valid strobe; transmit bytes
//                come from a one-deep buffer written with tx_load.
//  Ports       : clk, rst              - system clock, sync active-high reset
//                CPOL, CPHA            - bus mode, latched at SS_n fall
//                SCLK, MOSI, SS_n      - asynchronous bus inputs
//                MISO                  - serial out, 0 while deselected
//                tx_data, tx_load      - transmit buffer write
//                tx_pending            - buffer written, not yet consumed
//                rx_data, rx_valid     - received byte and its strobe
//                busy                  - frame in progress
//  Revision    : 1.0  initial release
// ============================================================================
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic              SCLK,
    input  logic              MOSI,
    input  logic              SS_n,
    output logic              MISO,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_pending,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);

    // ------------------------------------------------------------------
    // Pin synchronizers
    // ------------------------------------------------------------------
    logic sclk_rise, sclk_fall, unused_sclk_lvl;
    logic ss_lvl, ss_rise, ss_fall;
    logic mosi_s, unused_mosi_rise, unused_mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk_i   (clk),
        .rst_i   (rst),
        .async_i (SCLK),
        .level_o (unused_sclk_lvl),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk_i   (clk),
        .rst_i   (rst),
        .async_i (SS_n),
        .level_o (ss_lvl),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i   (clk),
        .rst_i   (rst),
        .async_i (MOSI),
        .level_o (mosi_s),
        .rise_o  (unused_mosi_rise),
        .fall_o  (unused_mosi_fall)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    spi_slv_state_e       state_q;
    spi_mode_t            mode_q;
    logic [DATA_W-1:0]    tx_sr_q;
    logic [DATA_W-1:0]    rx_sr_q;
    logic [DATA_W-1:0]    tx_buf_q;
    logic [DATA_W-1:0]    rx_data_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic                 tx_pending_q;
    logic                 rx_valid_q;
    logic                 byte_done_q;
    logic                 miso_q;
    // arm_sr_q fills with ones after reset; once its top bit is set the
    // SS_n synchronizer holds the real pin value. armed_q then requires a
    // genuine high level on SS_n before any fall is accepted, so a frame
    // already in progress at reset release is ignored.
    logic [SYNC_STAGES:0] arm_sr_q;
    logic                 armed_q;

    // ------------------------------------------------------------------
    // Combinational event decode
    // ------------------------------------------------------------------
    logic [1:0]        edges;
    logic              sample_edge;
    logic              shift_edge;
    logic              frame_start;
    logic              load_pt;
    logic [DATA_W-1:0] tx_next;

    assign edges       = edge_sel(mode_q, sclk_rise, sclk_fall);
    assign sample_edge = edges[1];
    assign shift_edge  = edges[0];
    assign frame_start = (state_q == IDLE) && ss_fall && armed_q;

    // A shift edge with bit_cnt==0 is the first edge of a byte in both
    // phases: for CPHA=0 it follows the last sample of the previous byte,
    // for CPHA=1 it opens the byte (including the very first one).
    assign load_pt = frame_start ||
                     ((state_q == XFER) && !ss_rise && shift_edge &&
                      (bit_cnt_q == '0));

    // A tx_load coinciding with a load point bypasses the buffer.
    assign tx_next = tx_load ? tx_data : tx_buf_q;

    // ------------------------------------------------------------------
    // FSM and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= '0;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            tx_buf_q     <= '0;
            rx_data_q    <= '0;
            bit_cnt_q    <= '0;
            tx_pending_q <= 1'b0;
            rx_valid_q   <= 1'b0;
            byte_done_q  <= 1'b0;
            miso_q       <= 1'b0;
            arm_sr_q     <= '0;
            armed_q      <= 1'b0;
        end else begin
            arm_sr_q <= {arm_sr_q[SYNC_STAGES-1:0], 1'b1};
            if (arm_sr_q[SYNC_STAGES] && ss_lvl) begin
                armed_q <= 1'b1;
            end

            // Byte completion is delivered one cycle after the final sample,
            // regardless of a simultaneous deselect.
            rx_valid_q  <= byte_done_q;
            byte_done_q <= 1'b0;
            if (byte_done_q) begin
                rx_data_q <= rx_sr_q;
            end

            if (tx_load) begin
                tx_buf_q     <= tx_data;
                tx_pending_q <= !load_pt;
            end else if (load_pt) begin
                tx_pending_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    bit_cnt_q <= '0;
                    if (frame_start) begin
                        mode_q  <= '{cpol: CPOL, cpha: CPHA};
                        tx_sr_q <= tx_next;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (ss_rise) begin
                        state_q <= IDLE;
                    end else if (sample_edge) begin
                        rx_sr_q <= {rx_sr_q[DATA_W-2:0], mosi_s};
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            bit_cnt_q   <= '0;
                            byte_done_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end else if (shift_edge) begin
                        if (bit_cnt_q == '0) begin
                            tx_sr_q <= tx_next;
                        end else begin
                            tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end
            endcase

            miso_q <= (state_q == XFER) ? tx_sr_q[DATA_W-1] : 1'b0;
        end
    end

    assign MISO       = miso_q;
    assign tx_pending = tx_pending_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign busy       = (state_q == XFER);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave
//  Description : Self-checking bench for spi_slave. The bench plays the SPI
//                master; expected received bytes go into a queue that a
//                monitor drains on every rx_valid strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       CPOL, CPHA, SCLK, MOSI, SS_n;
    logic       MISO;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_pending;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] rx_exp_q[$];

    always #5 clk = ~clk;

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .CPOL       (CPOL),
        .CPHA       (CPHA),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .SS_n       (SS_n),
        .MISO       (MISO),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_pending (tx_pending),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy)
    );

    // Scoreboard drain: every rx_valid must match the oldest expected byte.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            vectors++;
            if (rx_exp_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: rx_valid with rx_data=%02h, expected none", rx_data);
            end else begin
                logic [7:0] exp_b;
                exp_b = rx_exp_q.pop_front();
                if (rx_data !== exp_b) begin
                    errors++;
                    $display("FAIL rx_data: got %02h, expected %02h", rx_data, exp_b);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Master-side helpers
    // ------------------------------------------------------------------
    task automatic load_now(input logic [7:0] v);
        @(negedge clk);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic load_after(input int n, input logic [7:0] v);
        repeat (n) @(negedge clk);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic frame_begin(input logic cpol, input logic cpha);
        CPOL = cpol;
        CPHA = cpha;
        SCLK = cpol;
        repeat (4) @(negedge clk);
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (4) @(negedge clk);
        SS_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Shifts nbits of d MSB first; cap returns MISO at each sample edge.
    task automatic send_bits(input logic [7:0] d, input int nbits, input int half,
                             output logic [7:0] cap);
        cap = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (CPHA == 1'b0) begin
                MOSI = d[i];
                repeat (half) @(negedge clk);
                cap[i] = MISO;
                SCLK   = ~CPOL;
                repeat (half) @(negedge clk);
                SCLK   = CPOL;
            end else begin
                SCLK = ~CPOL;
                MOSI = d[i];
                repeat (half) @(negedge clk);
                cap[i] = MISO;
                SCLK   = CPOL;
                repeat (half) @(negedge clk);
            end
        end
    endtask

    task automatic check_drained(input string tag);
        vectors++;
        if (rx_exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_rx_missing: %0d bytes outstanding, expected 0", tag, rx_exp_q.size());
            rx_exp_q.delete();
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors += 5;
        if (MISO !== 1'b0)       begin errors++; $display("FAIL rst_miso: got %b, expected 0", MISO); end
        if (tx_pending !== 1'b0) begin errors++; $display("FAIL rst_tx_pending: got %b, expected 0", tx_pending); end
        if (rx_data !== 8'h00)   begin errors++; $display("FAIL rst_rx_data: got %02h, expected 00", rx_data); end
        if (rx_valid !== 1'b0)   begin errors++; $display("FAIL rst_rx_valid: got %b, expected 0", rx_valid); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_mode0();
        logic [7:0] cap;
        load_now(8'hA5);
        vectors++;
        if (tx_pending !== 1'b1) begin errors++; $display("FAIL m0_pending_set: got %b, expected 1", tx_pending); end
        frame_begin(1'b0, 1'b0);
        vectors += 2;
        if (tx_pending !== 1'b0) begin errors++; $display("FAIL m0_pending_clr: got %b, expected 0", tx_pending); end
        if (busy !== 1'b1)       begin errors++; $display("FAIL m0_busy: got %b, expected 1", busy); end
        rx_exp_q.push_back(8'h3C);
        send_bits(8'h3C, 8, 5, cap);
        vectors++;
        if (cap !== 8'hA5) begin errors++; $display("FAIL m0_miso: got %02h, expected a5", cap); end
        frame_end();
        vectors += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL m0_busy_end: got %b, expected 0", busy); end
        if (MISO !== 1'b0) begin errors++; $display("FAIL m0_miso_idle: got %b, expected 0", MISO); end
        check_drained("m0");
    endtask

    task automatic test_mode3();
        logic [7:0] cap;
        load_now(8'h55);
        frame_begin(1'b1, 1'b1);
        rx_exp_q.push_back(8'hAA);
        send_bits(8'hAA, 8, 5, cap);
        vectors++;
        if (cap !== 8'h55) begin errors++; $display("FAIL m3_miso: got %02h, expected 55", cap); end
        frame_end();
        check_drained("m3");
    endtask

    task automatic test_two_byte(input logic cpol, input logic cpha, input logic reload);
        logic [7:0] cap1, cap2, exp2;
        load_now(8'h5A);
        frame_begin(cpol, cpha);
        rx_exp_q.push_back(8'h12);
        rx_exp_q.push_back(8'h34);
        fork
            send_bits(8'h12, 8, 5, cap1);
            begin
                if (reload) load_after(41, 8'hC3);
            end
        join
        send_bits(8'h34, 8, 5, cap2);
        exp2 = reload ? 8'hC3 : 8'h5A;
        vectors += 3;
        if (cap1 !== 8'h5A) begin errors++; $display("FAIL tb_miso1 mode%0d%0d: got %02h, expected 5a", cpol, cpha, cap1); end
        if (cap2 !== exp2)  begin errors++; $display("FAIL tb_miso2 mode%0d%0d: got %02h, expected %02h", cpol, cpha, cap2, exp2); end
        if (tx_pending !== 1'b0) begin errors++; $display("FAIL tb_pending mode%0d%0d: got %b, expected 0", cpol, cpha, tx_pending); end
        frame_end();
        check_drained("two_byte");
    endtask

    task automatic test_abort();
        logic [7:0] cap;
        load_now(8'h3C);
        frame_begin(1'b0, 1'b0);
        send_bits(8'hF0, 4, 5, cap);
        SS_n = 1'b1;
        repeat (8) @(negedge clk);
        vectors += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, expected 0", busy); end
        if (MISO !== 1'b0) begin errors++; $display("FAIL abort_miso: got %b, expected 0", MISO); end
        load_now(8'h66);
        frame_begin(1'b0, 1'b0);
        rx_exp_q.push_back(8'h81);
        send_bits(8'h81, 8, 5, cap);
        vectors++;
        if (cap !== 8'h66) begin errors++; $display("FAIL abort_next_miso: got %02h, expected 66", cap); end
        frame_end();
        check_drained("abort");
    endtask

    task automatic test_reset_mid();
        logic [7:0] cap;
        load_now(8'h99);
        frame_begin(1'b0, 1'b0);
        send_bits(8'hE7, 3, 5, cap);
        load_now(8'h77);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors += 5;
        if (busy !== 1'b0)       begin errors++; $display("FAIL rmid_busy: got %b, expected 0", busy); end
        if (MISO !== 1'b0)       begin errors++; $display("FAIL rmid_miso: got %b, expected 0", MISO); end
        if (tx_pending !== 1'b0) begin errors++; $display("FAIL rmid_pending: got %b, expected 0", tx_pending); end
        if (rx_data !== 8'h00)   begin errors++; $display("FAIL rmid_rx_data: got %02h, expected 00", rx_data); end
        if (rx_valid !== 1'b0)   begin errors++; $display("FAIL rmid_rx_valid: got %b, expected 0", rx_valid); end
        // Rest of the aborted frame with SS_n still low must be ignored.
        send_bits(8'hFF, 8, 5, cap);
        vectors += 2;
        if (cap !== 8'h00) begin errors++; $display("FAIL rmid_ignored_miso: got %02h, expected 00", cap); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rmid_ignored_busy: got %b, expected 0", busy); end
        frame_end();
        load_now(8'hB4);
        frame_begin(1'b0, 1'b0);
        rx_exp_q.push_back(8'h7E);
        send_bits(8'h7E, 8, 5, cap);
        vectors++;
        if (cap !== 8'hB4) begin errors++; $display("FAIL rmid_next_miso: got %02h, expected b4", cap); end
        frame_end();
        check_drained("reset_mid");
    endtask

    task automatic test_back_to_back();
        logic [7:0] cap, cur, nxt, b;
        for (int m = 0; m < 4; m++) begin
            cur = 8'($urandom);
            load_now(cur);
            frame_begin(m[1], m[0]);
            for (int k = 0; k < 25; k++) begin
                b   = 8'($urandom);
                nxt = 8'($urandom);
                rx_exp_q.push_back(b);
                fork
                    send_bits(b, 8, 4, cap);
                    begin
                        if (k < 24) load_after(33, nxt);
                    end
                join
                vectors++;
                if (cap !== cur) begin
                    errors++;
                    $display("FAIL b2b_miso mode%0d byte%0d: got %02h, expected %02h", m, k, cap, cur);
                end
                cur = nxt;
            end
            frame_end();
            check_drained("b2b");
        end
    endtask

    initial begin
        rst     = 1'b1;
        CPOL    = 1'b0;
        CPHA    = 1'b0;
        SCLK    = 1'b0;
        MOSI    = 1'b0;
        SS_n    = 1'b1;
        tx_data = 8'h00;
        tx_load = 1'b0;

        test_reset();
        test_mode0();
        test_mode3();
        test_two_byte(1'b0, 1'b1, 1'b1);
        test_two_byte(1'b1, 1'b0, 1'b1);
        test_two_byte(1'b0, 1'b1, 1'b0);
        test_two_byte(1'b1, 1'b0, 1'b0);
        test_abort();
        test_reset_mid();
        test_back_to_back();

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI slave endpoint that sits directly downstream of the team's SPI_Master on the serial bus. It consumes SCLK, MOSI and SS_n, and produces MISO. All bus pins are oversampled in the system clock domain. Each received byte is delivered to the local side as a one-cycle strobe, and each byte to transmit is taken from a one-deep local buffer. All four CPOL/CPHA modes, MSB first, 8-bit frames, multi-byte frames while SS_n stays low.

Parameters:
DATA_W, 8, frame width in bits (bit counter is $clog2(DATA_W) wide)
SYNC_STAGES, 2, synchronizer depth on SCLK, MOSI, SS_n (minimum 2)

Ports:
clk  input  1  system clock; must be ≥ 8x SCLK frequency (SCLK half-period ≥ 4 clk)
rst  input  1  synchronous, active-high reset
CPOL  input  1  SCLK idle level; captured at SS_n fall, held for the frame
CPHA  input  1  0 = sample on leading edge, 1 = sample on trailing edge; captured at SS_n fall
SCLK  input  1  serial clock from master (asynchronous)
MOSI  input  1  serial data from master (asynchronous)
SS_n  input  1  active-low select (asynchronous)
MISO  output  1  serial data to master; 0 while deselected
tx_data  input  DATA_W  next byte to transmit
tx_load  input  1  writes tx_data into tx_buf
tx_pending  output  1  tx_buf written but not yet consumed
rx_data  output  DATA_W  last complete received byte
rx_valid  output  1  one-clk pulse: rx_data updated
busy  output  1  frame in progress (state XFER)

Behaviour:
- Reset (rst=1 at posedge clk): state IDLE, shift regs = 0, bit_cnt = 0, tx_buf = 0, tx_pending = 0, rx_data = 0, rx_valid = 0, busy = 0, MISO = 0, synchronizer flops = idle values (SCLK = 0, SS_n = 1). Reset mid-frame aborts immediately. No rx_valid is issued. After rst releases, the slave waits for a fresh SS_n fall.
- Synchronization: SYNC_STAGES flops per pin, plus one history flop on SCLK and SS_n. An edge is detected in the cycle where the last sync stage differs from the history flop. The MOSI value is taken from the last sync stage in that same cycle.
- Leading edge: SCLK leaves CPOL_lat. Trailing edge: SCLK returns to CPOL_lat. Sample edge = leading if CPHA_lat=0, else trailing. Shift edge = the other one.
- FSM IDLE:
  - MISO = 0, bit_cnt = 0.
  - On synced SS_n falling edge: latch CPOL/CPHA, load tx_sr ← tx_buf, clear tx_pending, go to XFER.
  - tx_sr[DATA_W-1] drives MISO from the next cycle, so the CPHA=0 first bit is valid before the first SCLK edge.
- FSM XFER, sample edge: rx_sr ← {rx_sr[DATA_W-2:0], MOSI_s}; bit_cnt++.
  - When bit_cnt reaches DATA_W-1 on a sample edge, in the next cycle: rx_data ← completed byte, rx_valid = 1 for exactly one cycle, bit_cnt wraps to 0.
- FSM XFER, shift edge:
  - CPHA=0: tx_sr shifts left. At the shift edge following the DATA_W-th sample, tx_sr instead loads tx_buf (next byte) and clears tx_pending.
  - CPHA=1: when bit_cnt==0, the shift edge is the first edge of a byte. tx_sr loads tx_buf (clears tx_pending); a reload at the first byte of the frame is permitted and yields identical data unless tx_load intervened. Otherwise tx_sr shifts left.
  - MISO = tx_sr[DATA_W-1] throughout XFER.
- Empty buffer: if tx_pending=0 at a load point, tx_buf is re-sent (last written value). This is not an error.
- tx_load: tx_buf ← tx_data, tx_pending=1. If tx_load coincides with a load point, the new tx_data is loaded into tx_sr directly and tx_pending stays 0.
- SS_n rise in XFER (synced): go to IDLE next cycle. A partial byte is discarded with no rx_valid. A complete byte whose rx_valid is due in the same cycle is still delivered. MISO returns to 0.
- SS_n glitch shorter than SYNC_STAGES+1 clk may be missed; this is an accepted limitation.
- Latency: rx_valid rises SYNC_STAGES+2 clk after the final sample-edge SCLK transition at the pin. MISO changes SYNC_STAGES+2 clk after a shift-edge pin transition.
- CPOL/CPHA changes during XFER are ignored until the next frame.

Decomposition:
- Shared package spi_pkg:
  - typedef enum logic {IDLE, XFER} spi_slv_state_e
  - localparams for default DATA_W
  - a spi_mode_t struct {cpol, cpha}
- Natural sub-module: spi_sync_edge. It contains the N-flop synchronizer plus history flop, outputs level/rise/fall, and is instantiated for SCLK and SS_n; MOSI uses the level output only.

Test Plan:
- Mode 0 (CPOL=0, CPHA=0), tx_load 0xA5, bench master sends 0x3C at clk/10 → rx_data=0x3C with a single rx_valid pulse; bits captured on MISO = 0xA5; tx_pending 1→0 at SS_n fall.
- Mode 3 (CPOL=1, CPHA=1), team SPI_Master driving tx_data=0xAA, slave tx_buf=0x55 → master rx_data=0x55, slave rx_data=0xAA, master done and slave rx_valid both seen.
- Modes 1 and 2, two-byte frame 0x12,0x34 with a second tx_load of 0xC3 between bytes → two rx_valid pulses (0x12, 0x34); MISO bytes = first tx_buf then 0xC3. Repeat with no second tx_load → first byte repeated.
- SS_n raised after 4 bits of 0xF0 → no rx_valid, busy falls, MISO=0. The next full frame 0x81 is received correctly (bit_cnt restarted).
- rst asserted mid-byte in mode 0 → all outputs at reset values next cycle. After release, the slave ignores the remainder of the frame until a new SS_n fall, then receives 0x7E correctly.
- SCLK at the limit (half-period = 4 clk) in all four modes, random 100 bytes → every byte matches in both directions.
